cpu_run_ctrl: RTL and testbench

Synthesizable run controller for the riscv32 core.
- Sequences the core's reset, then lets it run for a bounded cycle budget or until it signals halt.
- After the run, streams a parametrised window of architectural registers out over a valid/ready port.
- Sits between the top-level clock/reset and `cpu`; replaces fixed-delay bench sequencing with a reusable, checkable block (simulation or FPGA debug).

---
 rtl/cpu_run_ctrl_pkg.sv | 15 +
 rtl/cpu_run_ctrl_dump.sv | 77 +++++++
 rtl/cpu_run_ctrl.sv | 102 ++++++++++
 tb/tb_cpu_run_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and default widths for the riscv32 run controller.
// The optional zero-skip dump mode is selected with CPU_RUN_CTRL_SKIP_ZERO_EN.
package cpu_run_ctrl_pkg;

  localparam int DEF_XLEN     = 32;
  localparam int DEF_NUM_REGS = 32;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RUN,
    ST_DUMP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/cpu_run_ctrl_dump.sv
// Register-dump beat sequencer: walks DUMP_FIRST..DUMP_LAST, one beat per handshake.
// With CPU_RUN_CTRL_SKIP_ZERO_EN defined, zero-valued registers are scanned past without a beat.
module cpu_run_ctrl_dump
  import cpu_run_ctrl_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int RIDX_W     = $clog2(DEF_NUM_REGS),
  parameter int DUMP_FIRST = 1,
  parameter int DUMP_LAST  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_ready,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [RIDX_W-1:0] o_raddr,
  output logic              o_valid,
  output logic [RIDX_W-1:0] o_idx,
  output logic [XLEN-1:0]   o_data,
  output logic              o_drained
);

  logic [RIDX_W-1:0] r_raddr;
  logic              r_active;   // r_raddr still holds an index that has not been fetched
  logic              r_valid;
  logic [RIDX_W-1:0] r_idx;
  logic [XLEN-1:0]   r_data;

  logic w_slot_free;
  logic w_keep;
  logic w_last;

  assign w_slot_free = !r_valid || i_ready;
  assign w_last      = (r_raddr == RIDX_W'(DUMP_LAST));

`ifdef CPU_RUN_CTRL_SKIP_ZERO_EN
  assign w_keep = |i_rdata;
`else
  assign w_keep = 1'b1;
`endif

  // The fetch address runs one index ahead of the presented beat so that a
  // handshake can be followed by the next beat on the very next cycle.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_raddr  <= '0;
      r_active <= 1'b0;
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_data   <= '0;
    end else if (i_start) begin
      r_raddr  <= RIDX_W'(DUMP_FIRST);
      r_active <= 1'b1;
      r_valid  <= 1'b0;
    end else if (w_slot_free) begin
      if (r_active) begin
        r_valid <= w_keep;
        if (w_keep) begin
          r_idx  <= r_raddr;
          r_data <= i_rdata;
        end
        if (w_last) r_active <= 1'b0;
        else        r_raddr  <= r_raddr + RIDX_W'(1);
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_raddr   = r_raddr;
  assign o_valid   = r_valid;
  assign o_idx     = r_idx;
  assign o_data    = r_data;
  assign o_drained = !r_active && w_slot_free;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: holds the core in reset, runs it until halt or budget, then dumps registers.
// Build option CPU_RUN_CTRL_SKIP_ZERO_EN (in cpu_run_ctrl_dump) suppresses beats for zero registers.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter  int XLEN       = DEF_XLEN,
  parameter  int NUM_REGS   = DEF_NUM_REGS,
  parameter  int RST_CYCLES = 2,
  parameter  int MAX_CYCLES = 500,
  parameter  int CNT_W      = 32,
  parameter  int DUMP_FIRST = 1,
  parameter  int DUMP_LAST  = 2,
  localparam int RIDX_W     = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_i,
  output logic              cpu_rst,
  output logic [RIDX_W-1:0] rf_raddr,
  input  logic [XLEN-1:0]   rf_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [RIDX_W-1:0] dump_idx,
  output logic [XLEN-1:0]   dump_data,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              timeout,
  output logic              done
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_e            r_state;
  state_e            w_next;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0]  r_cycle_count;
  logic              r_timeout;

  logic w_dump_start;
  logic w_budget_hit;
  logic w_drained;

  assign w_budget_hit = (r_cycle_count == CNT_W'(MAX_CYCLES - 1));

  // NOTE: defaults are assigned before the case so no path leaves a signal unassigned (no latches).
  always_comb begin
    w_next       = r_state;
    w_dump_start = 1'b0;
    case (r_state)
      ST_HOLD: if (r_hold_cnt == HOLD_W'(RST_CYCLES - 1)) w_next = ST_RUN;
      ST_RUN: begin
        if (halt_i || w_budget_hit) begin
          w_next       = ST_DUMP;
          w_dump_start = 1'b1;
        end
      end
      ST_DUMP: if (w_drained) w_next = ST_DONE;
      ST_DONE: w_next = ST_DONE;
      default: w_next = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_HOLD;
      r_hold_cnt    <= '0;
      r_cycle_count <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_HOLD) r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      if (r_state == ST_RUN) begin
        r_cycle_count <= r_cycle_count + CNT_W'(1);
        // Halt takes precedence: a budget expiry coinciding with halt is not a timeout.
        if (!halt_i && w_budget_hit) r_timeout <= 1'b1;
      end
    end
  end

  cpu_run_ctrl_dump #(
    .XLEN       (XLEN),
    .RIDX_W     (RIDX_W),
    .DUMP_FIRST (DUMP_FIRST),
    .DUMP_LAST  (DUMP_LAST)
  ) u_dump (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_dump_start),
    .i_ready   (dump_ready),
    .i_rdata   (rf_rdata),
    .o_raddr   (rf_raddr),
    .o_valid   (dump_valid),
    .o_idx     (dump_idx),
    .o_data    (dump_data),
    .o_drained (w_drained)
  );

  assign cpu_rst     = (r_state != ST_RUN);
  assign done        = (r_state == ST_DONE);
  assign timeout     = r_timeout;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed vectors, corner sequences and randomized runs
// compared against a list-based model of the expected run length and dump beats.
module tb_cpu_run_ctrl;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int RIDX_W     = $clog2(NUM_REGS);
  localparam int RST_CYCLES = 2;
  localparam int MAX_CYCLES = 500;
  localparam int CNT_W      = 32;
  localparam int DUMP_FIRST = 1;
  localparam int DUMP_LAST  = 2;
`ifdef CPU_RUN_CTRL_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              halt_i;
  logic              cpu_rst;
  logic [RIDX_W-1:0] rf_raddr;
  logic [XLEN-1:0]   rf_rdata;
  logic              dump_valid;
  logic              dump_ready;
  logic [RIDX_W-1:0] dump_idx;
  logic [XLEN-1:0]   dump_data;
  logic [CNT_W-1:0]  cycle_count;
  logic              timeout;
  logic              done;

  logic [XLEN-1:0] rf_mem [NUM_REGS];
  assign rf_rdata = rf_mem[rf_raddr];

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .XLEN       (XLEN),
    .NUM_REGS   (NUM_REGS),
    .RST_CYCLES (RST_CYCLES),
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (CNT_W),
    .DUMP_FIRST (DUMP_FIRST),
    .DUMP_LAST  (DUMP_LAST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .halt_i      (halt_i),
    .cpu_rst     (cpu_rst),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_idx    (dump_idx),
    .dump_data   (dump_data),
    .cycle_count (cycle_count),
    .timeout     (timeout),
    .done        (done)
  );

  typedef struct {
    logic        halt;
    logic        exp_cpu_rst;
    logic [31:0] exp_cc;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          cyc;
  } beat_t;

  int    n_checks = 0;
  int    n_errors = 0;
  vec_t  vecs [6];
  beat_t exp_q [$];
  beat_t got_q [$];
  logic  pat [5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".cpu_rst"},     64'(cpu_rst),     64'd1);
    check({tag, ".rf_raddr"},    64'(rf_raddr),    64'd0);
    check({tag, ".dump_valid"},  64'(dump_valid),  64'd0);
    check({tag, ".dump_idx"},    64'(dump_idx),    64'd0);
    check({tag, ".dump_data"},   64'(dump_data),   64'd0);
    check({tag, ".cycle_count"}, 64'(cycle_count), 64'd0);
    check({tag, ".timeout"},     64'(timeout),     64'd0);
    check({tag, ".done"},        64'(done),        64'd0);
  endtask

  task automatic do_reset(input string tag);
    rst        = 1'b1;
    halt_i     = 1'b0;
    dump_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals({tag, ".reset"});
  endtask

  // Expected beats straight from the register contents: every index in the
  // window, minus zero-valued ones when skipping; with ready held high the
  // beat for window position p is visible p+1 cycles after DUMP entry.
  task automatic build_expected();
    beat_t b;
    exp_q.delete();
    for (int r = DUMP_FIRST; r <= DUMP_LAST; r++) begin
      if (!(SKIP && rf_mem[r] == '0)) begin
        b.idx  = r;
        b.data = rf_mem[r];
        b.cyc  = r - DUMP_FIRST + 1;
        exp_q.push_back(b);
      end
    end
  endtask

  // ready_mode: 0 = always ready, 1 = fixed stall pattern, 2 = random.
  task automatic run_scenario(input string tag, input int halt_cycle, input int ready_mode,
                              input int abort_after);
    int   exp_cc;
    bit   exp_to;
    int   edges;
    int   done_cyc;
    bit   prev_stall;
    int   prev_idx;
    logic [31:0] prev_data;
    logic r;
    beat_t b;

    if (halt_cycle >= 0 && halt_cycle < MAX_CYCLES) begin
      exp_cc = halt_cycle + 1;
      exp_to = 1'b0;
    end else begin
      exp_cc = MAX_CYCLES;
      exp_to = 1'b1;
    end
    do_reset(tag);
    build_expected();
    got_q.delete();

    rst   = 1'b0;
    edges = 0;
    while (edges < 20) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
      if (!cpu_rst) break;
    end
    check({tag, ".rst_edges"}, 64'(edges), 64'(RST_CYCLES));
    check({tag, ".cc_start"}, 64'(cycle_count), 64'd0);

    for (int k = 0; k < exp_cc; k++) begin
      check({tag, ".run_cc"}, 64'(cycle_count), 64'(k));
      halt_i = (k == halt_cycle);
      @(posedge clk);
      @(negedge clk);
    end
    halt_i = 1'b0;

    check({tag, ".dump_cpu_rst"}, 64'(cpu_rst), 64'd1);
    check({tag, ".dump_cc"}, 64'(cycle_count), 64'(exp_cc));
    check({tag, ".dump_timeout"}, 64'(timeout), 64'(exp_to));
    check({tag, ".dump_entry_valid"}, 64'(dump_valid), 64'd0);
    check({tag, ".dump_entry_raddr"}, 64'(rf_raddr), 64'(DUMP_FIRST));

    prev_stall = 1'b0;
    prev_idx   = 0;
    prev_data  = '0;
    done_cyc   = -1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = (cyc == 0) ? 1'b1 : ((cyc - 1 < 5) ? pat[cyc-1] : 1'b1);
        default: r = 1'($urandom_range(0, 1));
      endcase
      dump_ready = r;
      halt_i     = 1'($urandom_range(0, 1));
      if (prev_stall)
        check({tag, ".stall_hold"}, {31'd0, dump_valid, 32'(dump_idx) ^ 32'(prev_idx) ^ dump_data},
              {31'd0, 1'b1, prev_data});
      if (dump_valid && r) begin
        b.idx  = int'(dump_idx);
        b.data = dump_data;
        b.cyc  = cyc;
        got_q.push_back(b);
      end
      prev_stall = dump_valid && !r;
      prev_idx   = int'(dump_idx);
      prev_data  = dump_data;
      @(posedge clk);
      @(negedge clk);
      if (abort_after > 0 && got_q.size() >= abort_after) begin
        rst = 1'b1;
        #1;
        check_reset_vals({tag, ".abort_now"});
        @(negedge clk);
        check_reset_vals({tag, ".abort_next"});
        check({tag, ".abort_beat_idx"}, 64'(got_q[0].idx), 64'(exp_q[0].idx));
        check({tag, ".abort_beat_data"}, 64'(got_q[0].data), 64'(exp_q[0].data));
        halt_i     = 1'b0;
        dump_ready = 1'b0;
        return;
      end
    end
    halt_i     = 1'b0;
    dump_ready = 1'b0;

    check({tag, ".done_seen"}, 64'(done_cyc >= 0), 64'd1);
    check({tag, ".beat_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, ".beat_idx"}, 64'(got_q[i].idx), 64'(exp_q[i].idx));
      check({tag, ".beat_data"}, 64'(got_q[i].data), 64'(exp_q[i].data));
      if (ready_mode == 0) check({tag, ".beat_cyc"}, 64'(got_q[i].cyc), 64'(exp_q[i].cyc));
    end
    if (ready_mode == 0)
      check({tag, ".done_cyc"}, 64'(done_cyc), 64'(DUMP_LAST - DUMP_FIRST + 2));

    for (int i = 0; i < 3; i++) begin
      dump_ready = 1'($urandom_range(0, 1));
      halt_i     = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      check({tag, ".done_sticky"}, {61'd0, done, dump_valid, cpu_rst}, 64'b101);
      check({tag, ".cc_frozen"}, 64'(cycle_count), 64'(exp_cc));
    end
    halt_i     = 1'b0;
    dump_ready = 1'b0;
  endtask

  task automatic rand_rf();
    for (int i = 0; i < NUM_REGS; i++)
      rf_mem[i] = ($urandom_range(0, 2) == 0) ? '0 : $urandom;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    halt_i     = 1'b0;
    dump_ready = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = XLEN'(32'h1000 + i);

    // halt_i during HOLD must be ignored; count starts on the first RUN cycle.
    vecs[0] = '{halt: 1'b1, exp_cpu_rst: 1'b1, exp_cc: 32'd0};
    vecs[1] = '{halt: 1'b1, exp_cpu_rst: 1'b0, exp_cc: 32'd0};
    vecs[2] = '{halt: 1'b0, exp_cpu_rst: 1'b0, exp_cc: 32'd1};
    vecs[3] = '{halt: 1'b0, exp_cpu_rst: 1'b0, exp_cc: 32'd2};
    vecs[4] = '{halt: 1'b0, exp_cpu_rst: 1'b0, exp_cc: 32'd3};
    vecs[5] = '{halt: 1'b0, exp_cpu_rst: 1'b0, exp_cc: 32'd4};
    pat[0] = 1'b0; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0; pat[4] = 1'b1;

    do_reset("table");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      halt_i = vecs[i].halt;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("table[%0d].cpu_rst", i), 64'(cpu_rst), 64'(vecs[i].exp_cpu_rst));
      check($sformatf("table[%0d].cc", i), 64'(cycle_count), 64'(vecs[i].exp_cc));
      check($sformatf("table[%0d].timeout", i), 64'(timeout), 64'd0);
    end
    halt_i = 1'b0;

    rf_mem[1] = 32'h0000_00AA;
    rf_mem[2] = 32'h0000_0055;
    run_scenario("halt37", 37, 0, 0);
    run_scenario("timeout", -1, 0, 0);
    run_scenario("backpressure", 5, 1, 0);
    run_scenario("halt_at_budget", MAX_CYCLES - 1, 0, 0);

    rf_mem[1] = 32'h0000_0011;
    rf_mem[2] = 32'h0000_0022;
    run_scenario("abort", 3, 0, 1);
    rf_mem[1] = 32'h0;
    rf_mem[2] = 32'h0000_0055;
    run_scenario("restart_x1_zero", 10, 0, 0);
    rf_mem[2] = 32'h0;
    run_scenario("both_zero", 4, 0, 0);

    for (int t = 0; t < 20; t++) begin
      rand_rf();
      run_scenario($sformatf("rand%0d", t),
                   ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 80)),
                   ($urandom_range(0, 3) == 0) ? 0 : 2, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
